fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end of the Bitty CPU.
- Owns the program counter and reads the synchronous instruction ROM.
- Presents the fetched instruction and current PC to the core and to the branch resolver.
- Consumes the resolver's next-PC value and PC-advance enable, closing the fetch/branch loop.

Parameters:
- ADDR_W, 8, PC and ROM address width.
- INSTR_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  global run enable; fetches start only while high.
- en_pc  input  1  advance request from branch resolver (already run-qualified).
- new_pc  input  ADDR_W  next PC from branch resolver; sampled only when en_pc is accepted.
- mem_addr  output  ADDR_W  ROM read address.
- mem_data  input  INSTR_W  ROM read data, valid one cycle after mem_addr is presented.
- pc  output  ADDR_W  PC of the instruction in `instruction`.
- instruction  output  INSTR_W  registered instruction word.
- instr_valid  output  1  high while `instruction`/`pc` hold a fetched, unretired instruction.
- retired_count  output  16  count of retired instructions (optional feature).
- taken_count  output  16  count of non-sequential PC loads (optional feature).

Behaviour:
- Reset (synchronous, dominates everything):
  - State IDLE, pc=RESET_PC, instruction=0, instr_valid=0, counters=0.
  - Reset asserted mid-fetch or mid-execute aborts with no PC update. A ROM read in flight is discarded.
- mem_addr is always equal to the pc register (combinational).
- States:
  - IDLE: instr_valid=0. If run=1, go to FETCH next cycle; otherwise stay.
  - FETCH: ROM samples mem_addr this cycle. Always go to LATCH, even if run falls; an in-flight read always completes.
  - LATCH: mem_data is valid. At this edge, instruction<=mem_data and instr_valid<=1. Go to EXEC.
  - EXEC: instruction and pc held stable. On en_pc=1 at a clock edge:
    - pc<=new_pc, instr_valid<=0.
    - Go to FETCH if run=1, else IDLE.
  - EXEC with en_pc=0: hold indefinitely, including when run falls.
- Latency:
  - IDLE with run=1 to instr_valid=1 is 3 edges.
  - en_pc accept to the next instr_valid=1 is 3 edges.
  - Throughput is therefore one instruction per (3 + core execute) cycles.
- en_pc outside EXEC is ignored: no PC change, no counter change.
- new_pc is loaded verbatim. Any arithmetic wrap (e.g. 0xFF→0x00) is the resolver's job; the fetch unit imposes no range check.
- Simultaneous run fall and en_pc in EXEC: en_pc is accepted and PC is loaded, then the unit goes to IDLE.
- A taken load is new_pc != pc+1 (mod 2^ADDR_W) at acceptance.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - retired_count increments on every accepted en_pc.
  - taken_count increments on every accepted en_pc that is a taken load.
  - Both are 16-bit, wrap 0xFFFF→0, and are cleared by reset.
- Undefined: both outputs tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset/start:
  - Stimulus: reset for 2 cycles; ROM[0]=0x1234; run=1 after reset.
  - Response: mem_addr=0 throughout; instr_valid rises on the 3rd edge with instruction=0x1234, pc=0. Before that, instruction=0 and instr_valid=0.
- Sequential advance:
  - Stimulus: ROM[0]=0x1234, ROM[1]=0xABCD; in EXEC pulse en_pc with new_pc=1.
  - Response: instr_valid drops next edge; 3 edges after the pulse, instruction=0xABCD, pc=1. taken_count stays 0 and retired_count=1 (stats build).
- Taken branch:
  - Stimulus: in EXEC at pc=5, en_pc=1 with new_pc=0x40; ROM[0x40]=0x0042.
  - Response: pc=0x40, instruction=0x0042; taken_count increments by 1 (stats build).
- Wrap:
  - Stimulus: pc=0xFF in EXEC, en_pc with new_pc=0x00.
  - Response: fetch from address 0; counted as sequential, so taken_count unchanged.
- Run drop:
  - Stimulus: run falls during FETCH.
  - Response: unit still reaches EXEC with instr_valid=1. Then en_pc=1 with run=0 (forced) loads new_pc and the unit goes to IDLE; no further mem_addr change until run returns.
- Reset mid-operation:
  - Stimulus: reset asserted in LATCH with mem_data=0x7777.
  - Response: next cycle instruction=0, instr_valid=0, pc=RESET_PC, counters=0. en_pc pulses in IDLE have no effect.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch front end of the Bitty CPU.
//
// Owns the program counter, drives the synchronous instruction ROM and holds
// the fetched instruction until the branch resolver accepts it with en_pc.
// Sequence: IDLE -> FETCH -> LATCH -> EXEC -> (FETCH | IDLE).
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   run           global run enable
//   en_pc         advance request from branch resolver (only honoured in EXEC)
//   new_pc        next PC from branch resolver, loaded verbatim on accept
//   mem_addr      ROM read address (always equals pc)
//   mem_data      ROM read data, valid one cycle after mem_addr
//   pc            PC of the instruction held in `instruction`
//   instruction   registered instruction word
//   instr_valid   instruction/pc hold a fetched, unretired instruction
//   retired_count accepted en_pc count       (FETCH_STATS_EN, else 0)
//   taken_count   non-sequential load count  (FETCH_STATS_EN, else 0)
//
// Optional feature macro: FETCH_STATS_EN enables the two 16-bit counters.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               en_pc,
    input  logic [ADDR_W-1:0]  new_pc,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [15:0]        retired_count,
    output logic [15:0]        taken_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    logic accept;      // en_pc honoured this cycle
    logic load_instr;  // ROM data is valid this cycle

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run) state_d = FETCH;
            FETCH:   state_d = LATCH;   // in-flight read always completes
            LATCH:   state_d = EXEC;
            EXEC:    if (en_pc) state_d = run ? FETCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        accept     = 1'b0;
        load_instr = 1'b0;
        unique case (state_q)
            LATCH:   load_instr = 1'b1;
            EXEC:    accept     = en_pc;
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_instr) begin
                instr_q <= mem_data;
                valid_q <= 1'b1;
            end
            if (accept) begin
                pc_q    <= new_pc;
                valid_q <= 1'b0;
            end
        end
    end

    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign instr_valid = valid_q;

`ifdef FETCH_STATS_EN
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       retired_q;
    logic [15:0]       taken_q;

    // Sequential successor wraps naturally at ADDR_W bits.
    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
            taken_q   <= '0;
        end else if (accept) begin
            retired_q <= retired_q + 16'd1;
            if (new_pc != pc_inc) taken_q <= taken_q + 16'd1;
        end
    end

    assign retired_count = retired_q;
    assign taken_count   = taken_q;
`else
    assign retired_count = '0;
    assign taken_count   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        en_pc;
    logic [7:0]  new_pc;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data;
    logic [7:0]  pc;
    logic [15:0] instruction;
    logic        instr_valid;
    logic [15:0] retired_count;
    logic [15:0] taken_count;

    int n_vec  = 0;
    int n_fail = 0;

    int exp_ret = 0;
    int exp_tak = 0;

    logic [15:0] rom [256];
    logic [23:0] exp_q [$];   // {pc, instruction}
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .en_pc         (en_pc),
        .new_pc        (new_pc),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .pc            (pc),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .retired_count (retired_count),
        .taken_count   (taken_count)
    );

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) mem_data <= rom[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int cnt_exp(input int v);
`ifdef FETCH_STATS_EN
        return v & 16'hFFFF;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk_counters(input string tag);
        chk({tag, " retired_count"}, int'(retired_count), cnt_exp(exp_ret));
        chk({tag, " taken_count"},   int'(taken_count),   cnt_exp(exp_tak));
    endtask

    // Monitor: each rising instr_valid retires one scoreboard entry.
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_valid: got pc=0x%0h instr=0x%0h, expected none",
                         pc, instruction);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("mon pc", int'(pc), int'(e[23:16]));
                chk("mon instruction", int'(instruction), int'(e[15:0]));
                chk("mon mem_addr", int'(mem_addr), int'(e[23:16]));
            end
        end
        prev_valid <= instr_valid;
    end

    // Count negedges until instr_valid rises (bounded), check the edge count.
    task automatic wait_valid(input string name, input int exp_edges);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 12);
        chk({name, " latency"}, n, exp_edges);
    endtask

    // Accept en_pc in EXEC and expect the next instruction 3 edges later.
    task automatic step(input string name, input logic [7:0] v,
                        input logic [15:0] exp_instr, input bit taken);
        @(negedge clk);
        chk({name, " valid_before"}, int'(instr_valid), 1);
        en_pc  = 1'b1;
        new_pc = v;
        exp_q.push_back({v, exp_instr});
        @(posedge clk);
        #1 en_pc = 1'b0;
        exp_ret++;
        if (taken) exp_tak++;
        wait_valid(name, 3);
        chk_counters(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (rom[i]) rom[i] = 16'hDEAD;
        rom[8'h00] = 16'h1234;
        rom[8'h01] = 16'hABCD;
        rom[8'h02] = 16'h2222;
        rom[8'h05] = 16'h0505;
        rom[8'h10] = 16'h1010;
        rom[8'h20] = 16'h7777;
        rom[8'h40] = 16'h0042;
        rom[8'hFF] = 16'h00FF;

        reset  = 1'b1;
        run    = 1'b0;
        en_pc  = 1'b0;
        new_pc = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst pc", int'(pc), 0);
        chk("rst instruction", int'(instruction), 0);
        chk("rst instr_valid", int'(instr_valid), 0);
        chk("rst mem_addr", int'(mem_addr), 0);
        chk_counters("rst");

        // Start: instr_valid on the 3rd edge, nothing visible before
        run = 1'b1;
        exp_q.push_back({8'h00, 16'h1234});
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk("start instr_valid_early", int'(instr_valid), 0);
            chk("start instruction_early", int'(instruction), 0);
            chk("start mem_addr", int'(mem_addr), 0);
        end
        @(negedge clk);
        chk("start instr_valid_3rd", int'(instr_valid), 1);

        // Sequential, taken and wrap transitions
        step("seq_0_1",   8'h01, 16'hABCD, 1'b0);
        step("tkn_1_5",   8'h05, 16'h0505, 1'b1);
        step("tkn_5_40",  8'h40, 16'h0042, 1'b1);
        step("tkn_40_ff", 8'hFF, 16'h00FF, 1'b1);
        step("wrap_ff_0", 8'h00, 16'h1234, 1'b0);

        // Run drop during FETCH: read still completes into EXEC
        @(negedge clk);
        en_pc  = 1'b1;
        new_pc = 8'h02;
        exp_q.push_back({8'h02, 16'h2222});
        @(posedge clk);
        #1 en_pc = 1'b0;
        exp_ret++;
        exp_tak++;
        @(negedge clk);
        run = 1'b0;
        wait_valid("rundrop", 2);
        repeat (3) @(negedge clk);
        chk("rundrop hold valid", int'(instr_valid), 1);
        chk("rundrop hold pc", int'(pc), 8'h02);

        // en_pc with run low: PC loads, unit parks in IDLE
        en_pc  = 1'b1;
        new_pc = 8'h10;
        @(posedge clk);
        #1 en_pc = 1'b0;
        exp_ret++;
        exp_tak++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle instr_valid", int'(instr_valid), 0);
            chk("idle mem_addr", int'(mem_addr), 8'h10);
        end
        chk_counters("idle");

        // en_pc outside EXEC is ignored
        en_pc  = 1'b1;
        new_pc = 8'h33;
        repeat (2) @(negedge clk);
        en_pc = 1'b0;
        chk("ignored pc", int'(pc), 8'h10);
        chk_counters("ignored");

        // Run returns
        run = 1'b1;
        exp_q.push_back({8'h10, 16'h1010});
        wait_valid("resume", 3);

        // Reset asserted in LATCH with 0x7777 on mem_data
        @(negedge clk);
        en_pc  = 1'b1;
        new_pc = 8'h20;
        @(posedge clk);
        #1 en_pc = 1'b0;
        @(negedge clk);          // FETCH
        @(negedge clk);          // LATCH
        chk("midrst mem_data", int'(mem_data), 16'h7777);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;
        exp_ret = 0;
        exp_tak = 0;
        chk("midrst instruction", int'(instruction), 0);
        chk("midrst instr_valid", int'(instr_valid), 0);
        chk("midrst pc", int'(pc), 0);
        chk_counters("midrst");

        // en_pc pulses in IDLE after reset have no effect
        for (int i = 0; i < 3; i++) begin
            en_pc  = 1'b1;
            new_pc = 8'h55;
            @(negedge clk);
            en_pc = 1'b0;
            @(negedge clk);
        end
        chk("postrst pc", int'(pc), 0);
        chk("postrst instr_valid", int'(instr_valid), 0);
        chk_counters("postrst");

        chk("scoreboard empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
